vga_timing_gen: RTL and testbench

Parametrised, dual-mode VGA raster timing generator with a configurable pixel-fetch lead latency. It produces hsync, vsync, data-enable, pixel request and coordinates, plus frame/line start strobes, and gates RGB565 pixel data onto the output. It sits between the pixel source (game renderer / frame memory) and the VGA pins. The timing mode can be switched at run time; a switch takes effect only on a frame boundary.

---
 rtl/vga_timing_gen.sv | 246 ++++++++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with two run-time selectable timing modes.
// A request stage issues pixel coordinates one cycle after the raster
// counters; sync, display-enable and the frame/line strobes then travel
// through a LAT-deep shift pipeline so they line up with pixel data that
// the source returns LAT cycles after each request.
module vga_timing_gen #(
    parameter int          CW          = 11,
    parameter int          DATA_W      = 16,
    parameter int          LAT         = 1,
    parameter int          M0_H_SYNC   = 128,
    parameter int          M0_H_BACK   = 88,
    parameter int          M0_H_DISP   = 800,
    parameter int          M0_H_FRONT  = 40,
    parameter int          M0_V_SYNC   = 4,
    parameter int          M0_V_BACK   = 23,
    parameter int          M0_V_DISP   = 600,
    parameter int          M0_V_FRONT  = 1,
    parameter logic [1:0]  M0_POL      = 2'b00,
    parameter int          M1_H_SYNC   = 96,
    parameter int          M1_H_BACK   = 48,
    parameter int          M1_H_DISP   = 640,
    parameter int          M1_H_FRONT  = 16,
    parameter int          M1_V_SYNC   = 2,
    parameter int          M1_V_BACK   = 33,
    parameter int          M1_V_DISP   = 480,
    parameter int          M1_V_FRONT  = 10,
    parameter logic [1:0]  M1_POL      = 2'b00
) (
    input  logic              vga_clk,
    input  logic              sys_rst,
    input  logic              enable,
    input  logic              mode_sel,
    input  logic [DATA_W-1:0] pixel_data,
    output logic              data_req,
    output logic [CW-1:0]     pixel_xpos,
    output logic [CW-1:0]     pixel_ypos,
    output logic              vga_hs,
    output logic              vga_vs,
    output logic              vga_de,
    output logic [DATA_W-1:0] vga_rgb,
    output logic              frame_start,
    output logic              line_start,
    output logic              active_mode
);

    // Region boundaries per mode, expressed in counter width.
    // *_ACT_LO is the first active count, *_ACT_HI the first count past it.
    localparam logic [CW-1:0] H_SYNC0   = CW'(M0_H_SYNC);
    localparam logic [CW-1:0] H_ACT_LO0 = CW'(M0_H_SYNC + M0_H_BACK);
    localparam logic [CW-1:0] H_ACT_HI0 = CW'(M0_H_SYNC + M0_H_BACK + M0_H_DISP);
    localparam logic [CW-1:0] H_LAST0   = CW'(M0_H_SYNC + M0_H_BACK + M0_H_DISP + M0_H_FRONT - 1);
    localparam logic [CW-1:0] V_SYNC0   = CW'(M0_V_SYNC);
    localparam logic [CW-1:0] V_ACT_LO0 = CW'(M0_V_SYNC + M0_V_BACK);
    localparam logic [CW-1:0] V_ACT_HI0 = CW'(M0_V_SYNC + M0_V_BACK + M0_V_DISP);
    localparam logic [CW-1:0] V_LAST0   = CW'(M0_V_SYNC + M0_V_BACK + M0_V_DISP + M0_V_FRONT - 1);

    localparam logic [CW-1:0] H_SYNC1   = CW'(M1_H_SYNC);
    localparam logic [CW-1:0] H_ACT_LO1 = CW'(M1_H_SYNC + M1_H_BACK);
    localparam logic [CW-1:0] H_ACT_HI1 = CW'(M1_H_SYNC + M1_H_BACK + M1_H_DISP);
    localparam logic [CW-1:0] H_LAST1   = CW'(M1_H_SYNC + M1_H_BACK + M1_H_DISP + M1_H_FRONT - 1);
    localparam logic [CW-1:0] V_SYNC1   = CW'(M1_V_SYNC);
    localparam logic [CW-1:0] V_ACT_LO1 = CW'(M1_V_SYNC + M1_V_BACK);
    localparam logic [CW-1:0] V_ACT_HI1 = CW'(M1_V_SYNC + M1_V_BACK + M1_V_DISP);
    localparam logic [CW-1:0] V_LAST1   = CW'(M1_V_SYNC + M1_V_BACK + M1_V_DISP + M1_V_FRONT - 1);

    // Raster counters and the mode they are running in.
    logic [CW-1:0] cnt_h_q, cnt_h_d;
    logic [CW-1:0] cnt_v_q, cnt_v_d;
    logic          mode_q, mode_d;

    // Timing of the mode currently in effect.
    logic [CW-1:0] h_sync, h_act_lo, h_act_hi, h_last;
    logic [CW-1:0] v_sync, v_act_lo, v_act_hi, v_last;
    logic          pol_hs, pol_vs;

    // Region decode of the current counter position.
    logic          h_in_sync, v_in_sync, h_act, v_act;

    // Request stage (p0): coordinates plus the control bits that follow them.
    logic          vld_p0_q, vld_p0_d;
    logic [CW-1:0] xpos_p0_q, xpos_p0_d;
    logic [CW-1:0] ypos_p0_q, ypos_p0_d;
    logic          hs_p0_q, hs_p0_d;
    logic          vs_p0_q, vs_p0_d;
    logic          fs_p0_q, fs_p0_d;
    logic          ls_p0_q, ls_p0_d;

    // Display stage (p1): LAT-deep shift registers, index LAT-1 drives the pins.
    logic [LAT-1:0] de_p1_q, de_p1_d;
    logic [LAT-1:0] hs_p1_q, hs_p1_d;
    logic [LAT-1:0] vs_p1_q, vs_p1_d;
    logic [LAT-1:0] fs_p1_q, fs_p1_d;
    logic [LAT-1:0] ls_p1_q, ls_p1_d;

    // Select the boundaries and sync polarity of the active mode.
    always_comb begin
        if (mode_q) begin
            h_sync   = H_SYNC1;
            h_act_lo = H_ACT_LO1;
            h_act_hi = H_ACT_HI1;
            h_last   = H_LAST1;
            v_sync   = V_SYNC1;
            v_act_lo = V_ACT_LO1;
            v_act_hi = V_ACT_HI1;
            v_last   = V_LAST1;
            pol_hs   = M1_POL[1];
            pol_vs   = M1_POL[0];
        end else begin
            h_sync   = H_SYNC0;
            h_act_lo = H_ACT_LO0;
            h_act_hi = H_ACT_HI0;
            h_last   = H_LAST0;
            v_sync   = V_SYNC0;
            v_act_lo = V_ACT_LO0;
            v_act_hi = V_ACT_HI0;
            v_last   = V_LAST0;
            pol_hs   = M0_POL[1];
            pol_vs   = M0_POL[0];
        end
    end

    // Advance the raster; a new mode is latched only as the frame wraps,
    // or at once while the raster is idle.
    always_comb begin
        cnt_h_d = cnt_h_q;
        cnt_v_d = cnt_v_q;
        mode_d  = mode_q;
        if (!enable) begin
            cnt_h_d = '0;
            cnt_v_d = '0;
            mode_d  = mode_sel;
        end else if (cnt_h_q == h_last) begin
            cnt_h_d = '0;
            if (cnt_v_q == v_last) begin
                cnt_v_d = '0;
                mode_d  = mode_sel;
            end else begin
                cnt_v_d = cnt_v_q + CW'(1);
            end
        end else begin
            cnt_h_d = cnt_h_q + CW'(1);
        end
    end

    // Counter and mode registers.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            cnt_h_q <= '0;
            cnt_v_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            cnt_h_q <= cnt_h_d;
            cnt_v_q <= cnt_v_d;
            mode_q  <= mode_d;
        end
    end

    // ---- counters -> request stage (p0) ----
    // Decode the counter position into request, coordinates, sync and strobes.
    always_comb begin
        h_in_sync = (cnt_h_q < h_sync);
        v_in_sync = (cnt_v_q < v_sync);
        h_act     = (cnt_h_q >= h_act_lo) && (cnt_h_q < h_act_hi);
        v_act     = (cnt_v_q >= v_act_lo) && (cnt_v_q < v_act_hi);

        vld_p0_d  = 1'b0;
        xpos_p0_d = '0;
        ypos_p0_d = '0;
        hs_p0_d   = ~pol_hs;
        vs_p0_d   = ~pol_vs;
        fs_p0_d   = 1'b0;
        ls_p0_d   = 1'b0;
        if (enable) begin
            vld_p0_d = h_act && v_act;
            if (h_act && v_act) begin
                xpos_p0_d = cnt_h_q - h_act_lo;
                ypos_p0_d = cnt_v_q - v_act_lo;
            end
            hs_p0_d = h_in_sync ? pol_hs : ~pol_hs;
            vs_p0_d = v_in_sync ? pol_vs : ~pol_vs;
            ls_p0_d = (cnt_h_q == '0);
            fs_p0_d = (cnt_h_q == '0) && (cnt_v_q == '0);
        end
    end

    // Request stage registers; reset leaves sync at mode 0's inactive level.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            vld_p0_q  <= 1'b0;
            xpos_p0_q <= '0;
            ypos_p0_q <= '0;
            hs_p0_q   <= ~M0_POL[1];
            vs_p0_q   <= ~M0_POL[0];
            fs_p0_q   <= 1'b0;
            ls_p0_q   <= 1'b0;
        end else begin
            vld_p0_q  <= vld_p0_d;
            xpos_p0_q <= xpos_p0_d;
            ypos_p0_q <= ypos_p0_d;
            hs_p0_q   <= hs_p0_d;
            vs_p0_q   <= vs_p0_d;
            fs_p0_q   <= fs_p0_d;
            ls_p0_q   <= ls_p0_d;
        end
    end

    // ---- request stage (p0) -> display stage (p1, LAT deep) ----
    // Shift each control bit one place; the cast drops the oldest entry.
    always_comb begin
        de_p1_d = LAT'({de_p1_q, vld_p0_q});
        hs_p1_d = LAT'({hs_p1_q, hs_p0_q});
        vs_p1_d = LAT'({vs_p1_q, vs_p0_q});
        fs_p1_d = LAT'({fs_p1_q, fs_p0_q});
        ls_p1_d = LAT'({ls_p1_q, ls_p0_q});
    end

    // Display pipeline registers; reset flushes every slot to idle values.
    always_ff @(posedge vga_clk) begin
        if (sys_rst) begin
            de_p1_q <= '0;
            hs_p1_q <= {LAT{~M0_POL[1]}};
            vs_p1_q <= {LAT{~M0_POL[0]}};
            fs_p1_q <= '0;
            ls_p1_q <= '0;
        end else begin
            de_p1_q <= de_p1_d;
            hs_p1_q <= hs_p1_d;
            vs_p1_q <= vs_p1_d;
            fs_p1_q <= fs_p1_d;
            ls_p1_q <= ls_p1_d;
        end
    end

    // ---- display stage (p1) -> pins ----
    assign data_req    = vld_p0_q;
    assign pixel_xpos  = xpos_p0_q;
    assign pixel_ypos  = ypos_p0_q;
    assign vga_de      = de_p1_q[LAT-1];
    assign vga_hs      = hs_p1_q[LAT-1];
    assign vga_vs      = vs_p1_q[LAT-1];
    assign frame_start = fs_p1_q[LAT-1];
    assign line_start  = ls_p1_q[LAT-1];
    assign active_mode = mode_q;
    assign vga_rgb     = vga_de ? pixel_data : '0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen with shrunken timings and LAT = 3.
// The stimulus side steps a raster model (plain integer position, mode and a
// delay queue) and pushes the expected outputs of every cycle; a monitor on
// the falling edge pops and compares, and also measures whole frames.
module tb_vga_timing_gen;

    localparam int CW = 11;
    localparam int DATA_W = 16;
    localparam int LAT = 3;

    localparam int M0_HS = 8, M0_HB = 6, M0_HD = 20, M0_HF = 4;
    localparam int M0_VS = 2, M0_VB = 3, M0_VD = 10, M0_VF = 2;
    localparam int M1_HS = 5, M1_HB = 4, M1_HD = 16, M1_HF = 3;
    localparam int M1_VS = 1, M1_VB = 2, M1_VD = 8,  M1_VF = 3;
    localparam logic [1:0] M0_POL = 2'b00;
    localparam logic [1:0] M1_POL = 2'b10;

    localparam int K_HS = 0, K_HB = 1, K_HD = 2, K_HF = 3;
    localparam int K_VS = 4, K_VB = 5, K_VD = 6, K_VF = 7;

    logic              clk = 1'b0;
    logic              rst, en, ms;
    logic [DATA_W-1:0] pix;
    logic              data_req, vga_hs, vga_vs, vga_de;
    logic              frame_start, line_start, active_mode;
    logic [CW-1:0]     pixel_xpos, pixel_ypos;
    logic [DATA_W-1:0] vga_rgb;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .CW(CW), .DATA_W(DATA_W), .LAT(LAT),
        .M0_H_SYNC(M0_HS), .M0_H_BACK(M0_HB), .M0_H_DISP(M0_HD), .M0_H_FRONT(M0_HF),
        .M0_V_SYNC(M0_VS), .M0_V_BACK(M0_VB), .M0_V_DISP(M0_VD), .M0_V_FRONT(M0_VF),
        .M0_POL(M0_POL),
        .M1_H_SYNC(M1_HS), .M1_H_BACK(M1_HB), .M1_H_DISP(M1_HD), .M1_H_FRONT(M1_HF),
        .M1_V_SYNC(M1_VS), .M1_V_BACK(M1_VB), .M1_V_DISP(M1_VD), .M1_V_FRONT(M1_VF),
        .M1_POL(M1_POL)
    ) dut (
        .vga_clk(clk), .sys_rst(rst), .enable(en), .mode_sel(ms), .pixel_data(pix),
        .data_req(data_req), .pixel_xpos(pixel_xpos), .pixel_ypos(pixel_ypos),
        .vga_hs(vga_hs), .vga_vs(vga_vs), .vga_de(vga_de), .vga_rgb(vga_rgb),
        .frame_start(frame_start), .line_start(line_start), .active_mode(active_mode)
    );

    typedef struct {
        bit req; int x; int y; bit hs; bit vs; bit de; bit fs; bit ls;
    } p0_t;

    typedef struct {
        bit req; int x; int y; bit hs; bit vs; bit de; bit fs; bit ls; int rgb; bit mode;
    } exp_t;

    p0_t  dq[$];
    exp_t exp_q[$];
    int   m_h = 0, m_v = 0;
    bit   m_mode = 1'b0;

    int tests = 0, fails = 0;
    int n_ticks = 0, n_cmp = 0;

    function automatic int tm(bit m, int k);
        case (k)
            K_HS: return m ? M1_HS : M0_HS;
            K_HB: return m ? M1_HB : M0_HB;
            K_HD: return m ? M1_HD : M0_HD;
            K_HF: return m ? M1_HF : M0_HF;
            K_VS: return m ? M1_VS : M0_VS;
            K_VB: return m ? M1_VB : M0_VB;
            K_VD: return m ? M1_VD : M0_VD;
            default: return m ? M1_VF : M0_VF;
        endcase
    endfunction

    function automatic int h_tot(bit m);
        return tm(m, K_HS) + tm(m, K_HB) + tm(m, K_HD) + tm(m, K_HF);
    endfunction

    function automatic int v_tot(bit m);
        return tm(m, K_VS) + tm(m, K_VB) + tm(m, K_VD) + tm(m, K_VF);
    endfunction

    function automatic bit pol_h(bit m);
        return m ? M1_POL[1] : M0_POL[1];
    endfunction

    function automatic bit pol_v(bit m);
        return m ? M1_POL[0] : M0_POL[0];
    endfunction

    function automatic p0_t idle(bit m);
        p0_t p;
        p.req = 1'b0; p.x = 0; p.y = 0;
        p.hs = !pol_h(m); p.vs = !pol_v(m);
        p.de = 1'b0; p.fs = 1'b0; p.ls = 1'b0;
        return p;
    endfunction

    // One clock edge of the reference raster, given the inputs sampled there.
    function automatic void model_step(bit r, bit e, bit s);
        p0_t  n, d;
        exp_t x;
        int   ha, va;
        if (r) begin
            m_h = 0; m_v = 0; m_mode = 1'b0;
            n = idle(1'b0);
            dq.delete();
            for (int i = 0; i <= LAT; i++) dq.push_back(n);
        end else begin
            n = idle(m_mode);
            if (e) begin
                ha = tm(m_mode, K_HS) + tm(m_mode, K_HB);
                va = tm(m_mode, K_VS) + tm(m_mode, K_VB);
                n.hs  = (m_h < tm(m_mode, K_HS)) ? pol_h(m_mode) : !pol_h(m_mode);
                n.vs  = (m_v < tm(m_mode, K_VS)) ? pol_v(m_mode) : !pol_v(m_mode);
                n.ls  = (m_h == 0);
                n.fs  = (m_h == 0) && (m_v == 0);
                n.req = (m_h >= ha) && (m_h < ha + tm(m_mode, K_HD)) &&
                        (m_v >= va) && (m_v < va + tm(m_mode, K_VD));
                n.de  = n.req;
                if (n.req) begin
                    n.x = m_h - ha;
                    n.y = m_v - va;
                end
                m_h++;
                if (m_h == h_tot(m_mode)) begin
                    m_h = 0;
                    m_v++;
                    if (m_v == v_tot(m_mode)) begin
                        m_v = 0;
                        m_mode = s;
                    end
                end
            end else begin
                m_h = 0; m_v = 0; m_mode = s;
            end
            dq.push_back(n);
            while (dq.size() > LAT + 1) d = dq.pop_front();
        end
        d = dq[0];
        x.req = n.req; x.x = n.x; x.y = n.y;
        x.hs = d.hs; x.vs = d.vs; x.de = d.de; x.fs = d.fs; x.ls = d.ls;
        x.rgb = d.de ? ((d.y % 32) * 2048 + (d.x % 2048)) : 0;
        x.mode = m_mode;
        exp_q.push_back(x);
    endfunction

    // Drive inputs for the coming edge, then record what that edge must produce.
    task automatic tick(input bit r, input bit e, input bit s);
        rst = r; en = e; ms = s;
        @(posedge clk);
        model_step(r, e, s);
        n_ticks++;
        #2;
    endtask

    task automatic run_until(input int h, input int v, input bit e, input bit s, input int budget);
        int k;
        k = 0;
        while (!(m_h == h && m_v == v) && k < budget) begin
            tick(1'b0, e, s);
            k++;
        end
        tests++;
        if (!(m_h == h && m_v == v)) begin
            fails++;
            $display("FAIL reach_pos got (%0d,%0d) want (%0d,%0d)", m_h, m_v, h, v);
        end
    endtask

    // Pixel source: returns a coordinate code LAT cycles after each request,
    // and noise for non-request cycles so that output gating is exercised.
    logic [DATA_W-1:0] src_q[$];
    initial begin
        pix = '0;
        for (int i = 0; i < LAT; i++) src_q.push_back('0);
        forever begin
            @(posedge clk);
            #1;
            if (data_req === 1'b1) src_q.push_back({pixel_ypos[4:0], pixel_xpos[10:0]});
            else                   src_q.push_back(DATA_W'($urandom));
            pix = src_q.pop_front();
        end
    end

    // Monitor: per-cycle scoreboard compare plus whole-frame measurements.
    exp_t mon_e;
    int   last_dis = 0, prev_fs = 0, de_cnt = 0, n_m0 = 0, n_m1 = 0;
    bit   have_fs = 1'b0, fr_mode = 1'b0;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            n_cmp++;
            tests++;
            if ({data_req, pixel_xpos, pixel_ypos, vga_hs, vga_vs, vga_de, frame_start,
                 line_start, active_mode, vga_rgb} !==
                {mon_e.req, CW'(mon_e.x), CW'(mon_e.y), mon_e.hs, mon_e.vs, mon_e.de, mon_e.fs,
                 mon_e.ls, mon_e.mode, DATA_W'(mon_e.rgb)}) begin
                fails++;
                $display("FAIL cycle %0d outputs got req=%b x=%0d y=%0d hs=%b vs=%b de=%b fs=%b ls=%b mode=%b rgb=%h want req=%b x=%0d y=%0d hs=%b vs=%b de=%b fs=%b ls=%b mode=%b rgb=%h",
                         n_cmp, data_req, pixel_xpos, pixel_ypos, vga_hs, vga_vs, vga_de,
                         frame_start, line_start, active_mode, vga_rgb,
                         mon_e.req, mon_e.x, mon_e.y, mon_e.hs, mon_e.vs, mon_e.de,
                         mon_e.fs, mon_e.ls, mon_e.mode, mon_e.rgb[DATA_W-1:0]);
            end
            if (rst !== 1'b0 || en !== 1'b1) last_dis = n_cmp;
            if (frame_start === 1'b1) begin
                if (have_fs && last_dis < prev_fs - LAT - 1) begin
                    tests++;
                    if (de_cnt != tm(fr_mode, K_HD) * tm(fr_mode, K_VD) ||
                        n_cmp - prev_fs != h_tot(fr_mode) * v_tot(fr_mode)) begin
                        fails++;
                        $display("FAIL frame_shape mode %0d got de=%0d period=%0d want de=%0d period=%0d",
                                 fr_mode, de_cnt, n_cmp - prev_fs,
                                 tm(fr_mode, K_HD) * tm(fr_mode, K_VD),
                                 h_tot(fr_mode) * v_tot(fr_mode));
                    end
                    if (fr_mode) n_m1++;
                    else         n_m0++;
                end
                have_fs = 1'b1;
                prev_fs = n_cmp;
                de_cnt  = 0;
                fr_mode = active_mode;
            end
            if (vga_de === 1'b1) de_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap;
        bit s, r;
        rst = 1'b1; en = 1'b1; ms = 1'b0;

        // Reset with enable high, then two mode 0 frames.
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        repeat (2 * h_tot(0) * v_tot(0) + 5) tick(1'b0, 1'b1, 1'b0);

        // Mid-frame mode_sel activity; the value at the frame end selects mode 1.
        run_until(0, 8, 1'b1, 1'b0, 2000);
        gap = 0;
        while (!(m_h == 0 && m_v == 0) && gap < 2000) begin
            tick(1'b0, 1'b1, (m_v >= 12) ? 1'b1 : bit'($urandom_range(0, 1)));
            gap++;
        end
        tests++;
        if (m_mode != 1'b1) begin
            fails++;
            $display("FAIL switch_mode model mode %0d want 1", m_mode);
        end
        repeat (h_tot(1) * v_tot(1) + 20) tick(1'b0, 1'b1, 1'b1);

        // Enable gap of 50 cycles mid-line, with a mode flip while idle.
        run_until(10, 5, 1'b1, 1'b1, 2000);
        for (int i = 0; i < 50; i++) tick(1'b0, 1'b0, (i >= 20 && i < 30) ? 1'b0 : 1'b1);
        repeat (h_tot(1) * v_tot(1) + 200) tick(1'b0, 1'b1, 1'b1);

        // Reset in the middle of a frame, then a clean mode 0 frame.
        run_until(15, 7, 1'b1, 1'b1, 2000);
        tick(1'b1, 1'b1, 1'b1);
        repeat (h_tot(0) * v_tot(0) + 60) tick(1'b0, 1'b1, 1'b0);

        // Random traffic: enable gaps, mode flips and rare resets.
        gap = 0;
        s = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 599) == 0);
            if (gap == 0 && $urandom_range(0, 399) == 0) gap = $urandom_range(1, 40);
            if ($urandom_range(0, 149) == 0) s = !s;
            tick(r, gap == 0, s);
            if (gap > 0) gap--;
        end

        repeat (3) @(negedge clk);
        tests++;
        if (n_cmp != n_ticks) begin
            fails++;
            $display("FAIL scoreboard_drain got %0d compares want %0d", n_cmp, n_ticks);
        end
        tests++;
        if (n_m0 < 2) begin
            fails++;
            $display("FAIL mode0_frames got %0d want at least 2", n_m0);
        end
        tests++;
        if (n_m1 < 1) begin
            fails++;
            $display("FAIL mode1_frames got %0d want at least 1", n_m1);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
